// File: rtl/neuron_core_pkg.sv
// Shared definitions for the neuron core Wishbone front-end: region codes,
// address field positions, FSM state type and the captured-request record.
package neuron_core_pkg;

  localparam logic [1:0] REGION_SYN   = 2'b00;
  localparam logic [1:0] REGION_PARAM = 2'b01;
  localparam logic [1:0] REGION_SPIKE = 2'b10;

  localparam int REGION_MSB   = 14;
  localparam int REGION_LSB   = 13;
  localparam int SYN_WORD_MSB = 12;
  localparam int SYN_WORD_LSB = 2;
  localparam int PNUM_MSB     = 8;
  localparam int PNUM_LSB     = 4;
  localparam int PWORD_MSB    = 3;
  localparam int PWORD_LSB    = 2;
  localparam int SPK_WORD_MSB = 4;
  localparam int SPK_WORD_LSB = 2;

  // Only the low 15 address bits matter once the base-address hit is known.
  localparam int REQ_ADR_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [3:0]           sel;
    logic [REQ_ADR_W-1:0] adr;
    logic [31:0]          dat;
  } wb_req_t;

endpackage

// File: rtl/neuron_core_wb_ctrl_addr_dec.sv
// AddressDecoder_256x256: combinational region decode of a core-relative
// byte address.
//   addr             in  15  core-relative byte address
//   synap_matrix     out 1   synapse SRAM region
//   param            out 1   parameter-register region
//   neuron_spike_out out 1   spike readout region
//   param_num        out 5   parameter index field
// An address in none of the three regions is the unmapped region.
module AddressDecoder_256x256
  import neuron_core_pkg::*;
(
  input  logic [REQ_ADR_W-1:0] addr,
  output logic                 synap_matrix,
  output logic                 param,
  output logic                 neuron_spike_out,
  output logic [4:0]           param_num
);

  logic [1:0] region;
  logic       unused_bits;

  assign region           = addr[REGION_MSB:REGION_LSB];
  assign synap_matrix     = (region == REGION_SYN);
  assign param            = (region == REGION_PARAM);
  assign neuron_spike_out = (region == REGION_SPIKE);
  assign param_num        = addr[PNUM_MSB:PNUM_LSB];
  assign unused_bits      = ^{addr[12:9], addr[3:0]};

endmodule

// File: rtl/neuron_core_wb_ctrl.sv
// neuron_core_wb_ctrl: Wishbone slave front-end of the 256x256 neuron core.
// Decodes a bus cycle into a synapse SRAM, parameter or spike access, runs it
// through IDLE -> ACCESS -> (WAIT) -> ACK and returns a one-cycle ack with
// registered read data.
//   wb_clk_i/wb_rst_n         clock, async active-low reset
//   wbs_*                     Wishbone slave port
//   syn_*                     synapse SRAM port (read latency SYN_RD_LATENCY)
//   param_*                   parameter register write/read strobes and data
//   spike_out_i               neuron spike vector, sampled on spike reads
module neuron_core_wb_ctrl
  import neuron_core_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK      = 32'hFFFF_8000,
  parameter int          SYN_RD_LATENCY = 1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic         syn_en_o,
  output logic         syn_we_o,
  output logic [3:0]   syn_wmask_o,
  output logic [10:0]  syn_addr_o,
  output logic [31:0]  syn_wdata_o,
  input  logic [31:0]  syn_rdata_i,
  output logic         param_we_o,
  output logic         param_re_o,
  output logic [4:0]   param_num_o,
  output logic [1:0]   param_word_o,
  output logic [31:0]  param_wdata_o,
  input  logic [31:0]  param_rdata_i,
  input  logic [255:0] spike_out_i
);

  localparam int CNT_W = $clog2(SYN_RD_LATENCY + 1);

  state_e           state_q, state_d;
  wb_req_t          req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      dat_q;

  logic       hit;
  logic       cnt_last;
  logic       dec_syn, dec_param, dec_spike;
  logic [4:0] dec_pnum;
  logic [2:0] spk_idx;
  logic       unused_adr;

  assign hit = wbs_cyc_i & wbs_stb_i &
               ((wbs_adr_i & BASE_MASK) == (BASE_ADDR & BASE_MASK));

  AddressDecoder_256x256 u_dec (
    .addr             (req_q.adr),
    .synap_matrix     (dec_syn),
    .param            (dec_param),
    .neuron_spike_out (dec_spike),
    .param_num        (dec_pnum)
  );

  assign cnt_last   = (cnt_q == CNT_W'(SYN_RD_LATENCY));
  assign spk_idx    = req_q.adr[SPK_WORD_MSB:SPK_WORD_LSB];
  assign unused_adr = ^req_q.adr[1:0];

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hit) state_d = ST_ACCESS;
      ST_ACCESS: state_d = (dec_syn && !req_q.we) ? ST_WAIT : ST_ACK;
      // A master giving up mid-read is dropped silently.
      ST_WAIT: begin
        if (!wbs_cyc_i)    state_d = ST_IDLE;
        else if (cnt_last) state_d = ST_ACK;
      end
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request capture, latency counter and read-data register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      req_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hit) begin
            req_q.we  <= wbs_we_i;
            req_q.sel <= wbs_sel_i;
            req_q.adr <= wbs_adr_i[REQ_ADR_W-1:0];
            req_q.dat <= wbs_dat_i;
          end
        end
        ST_ACCESS: begin
          cnt_q <= CNT_W'(1);
          if (req_q.we)       dat_q <= '0;
          else if (dec_param) dat_q <= param_rdata_i;
          else if (dec_spike) dat_q <= spike_out_i[{spk_idx, 5'd0} +: 32];
          else if (!dec_syn)  dat_q <= '0;  // unmapped read
          // synapse reads load in WAIT
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (wbs_cyc_i && cnt_last) dat_q <= syn_rdata_i;
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobes only while in ACCESS
  always_comb begin
    wbs_ack_o   = (state_q == ST_ACK);
    syn_en_o    = 1'b0;
    syn_we_o    = 1'b0;
    syn_wmask_o = 4'h0;
    param_we_o  = 1'b0;
    param_re_o  = 1'b0;
    if (state_q == ST_ACCESS) begin
      if (dec_syn) begin
        syn_en_o    = 1'b1;
        syn_we_o    = req_q.we;
        syn_wmask_o = req_q.sel;
      end
      if (dec_param) begin
        // Parameters are whole-word registers; partial writes are ignored.
        param_we_o = req_q.we & (req_q.sel == 4'hF);
        param_re_o = ~req_q.we;
      end
    end
  end

  assign wbs_dat_o     = dat_q;
  assign syn_addr_o    = req_q.adr[SYN_WORD_MSB:SYN_WORD_LSB];
  assign syn_wdata_o   = req_q.dat;
  assign param_num_o   = dec_pnum;
  assign param_word_o  = req_q.adr[PWORD_MSB:PWORD_LSB];
  assign param_wdata_o = req_q.dat;

endmodule

// File: tb/tb_neuron_core_wb_ctrl.sv
module tb_neuron_core_wb_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared bus payload; each DUT has its own cyc/stb.
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        cyc1 = 1'b0, stb1 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;

  logic        ack1, ack3;
  logic [31:0] dat1, dat3;
  logic        sen1, swe1, pwe1, pre1, sen3, swe3, pwe3, pre3;
  logic [3:0]  wm1, wm3;
  logic [10:0] sa1, sa3;
  logic [31:0] swd1, swd3, srd1, srd3, pwd1, pwd3, prd1, prd3;
  logic [4:0]  pn1, pn3;
  logic [1:0]  pw1, pw3;
  logic [255:0] spike;

  int checks = 0;
  int failures = 0;

  neuron_core_wb_ctrl #(.SYN_RD_LATENCY(1)) u_l1 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc1), .wbs_stb_i(stb1), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack1), .wbs_dat_o(dat1),
    .syn_en_o(sen1), .syn_we_o(swe1), .syn_wmask_o(wm1), .syn_addr_o(sa1),
    .syn_wdata_o(swd1), .syn_rdata_i(srd1),
    .param_we_o(pwe1), .param_re_o(pre1), .param_num_o(pn1), .param_word_o(pw1),
    .param_wdata_o(pwd1), .param_rdata_i(prd1), .spike_out_i(spike));

  neuron_core_wb_ctrl #(.SYN_RD_LATENCY(3)) u_l3 (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc3), .wbs_stb_i(stb3), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack3), .wbs_dat_o(dat3),
    .syn_en_o(sen3), .syn_we_o(swe3), .syn_wmask_o(wm3), .syn_addr_o(sa3),
    .syn_wdata_o(swd3), .syn_rdata_i(srd3),
    .param_we_o(pwe3), .param_re_o(pre3), .param_num_o(pn3), .param_word_o(pw3),
    .param_wdata_o(pwd3), .param_rdata_i(prd3), .spike_out_i(spike));

  // Parameter file model: word value encodes its own index.
  assign prd1 = 32'hA500_0000 | {25'd0, pn1, pw1};
  assign prd3 = 32'hA500_0000 | {25'd0, pn3, pw3};

  // Synapse SRAM models, latency 1 and 3.
  logic [31:0] mem1 [2048];
  logic [31:0] mem3 [2048];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  assign srd1 = p1;
  assign srd3 = p3[2];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (sen1 && swe1 && wm1[b]) mem1[sa1][8*b +: 8] <= swd1[8*b +: 8];
      if (sen3 && swe3 && wm3[b]) mem3[sa3][8*b +: 8] <= swd3[8*b +: 8];
    end
    p1    <= (sen1 && !swe1) ? mem1[sa1] : 32'h0;
    p3[0] <= (sen3 && !swe3) ? mem3[sa3] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [3:0]  strb;   // {syn_en, syn_we, param_we, param_re} in ACCESS
    logic [3:0]  wmask;
    logic [10:0] saddr;
    logic [4:0]  pnum;
    logic [1:0]  pword;
    int          ack;    // cycle of ack, cycle 0 = request cycle
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] strb_of(input int inst);
    return (inst == 1) ? {sen1, swe1, pwe1, pre1} : {sen3, swe3, pwe3, pre3};
  endfunction

  function automatic logic ack_of(input int inst);
    return (inst == 1) ? ack1 : ack3;
  endfunction

  function automatic logic [31:0] dat_of(input int inst);
    return (inst == 1) ? dat1 : dat3;
  endfunction

  task automatic set_cyc(input int inst, input logic v);
    if (inst == 1) begin cyc1 = v; stb1 = v; end
    else           begin cyc3 = v; stb3 = v; end
  endtask

  task automatic run_vec(input int inst, input vec_t v);
    int   got;
    logic late_strb;
    got = 0;
    late_strb = 1'b0;
    @(negedge clk);
    we = v.we; adr = v.adr; dat = v.dat; sel = v.sel;
    set_cyc(inst, 1'b1);
    for (int c = 1; c <= 20 && got == 0; c++) begin
      @(negedge clk);
      // Inputs wander after capture; the DUT must ignore them.
      if (c == 1) begin
        chk({v.name, ".strb"}, 64'(strb_of(inst)), 64'(v.strb));
        chk({v.name, ".wmask"}, 64'((inst == 1) ? wm1 : wm3), 64'(v.wmask));
        chk({v.name, ".saddr"}, 64'((inst == 1) ? sa1 : sa3), 64'(v.saddr));
        chk({v.name, ".pnum"}, 64'((inst == 1) ? pn1 : pn3), 64'(v.pnum));
        chk({v.name, ".pword"}, 64'((inst == 1) ? pw1 : pw3), 64'(v.pword));
        we = ~v.we; adr = 32'h3000_6FFC;
      end else if (strb_of(inst) != 4'h0) begin
        late_strb = 1'b1;
      end
      if (ack_of(inst)) begin
        got = c;
        set_cyc(inst, 1'b0);
      end
    end
    if (got == 0) set_cyc(inst, 1'b0);
    chk({v.name, ".ack_cycle"}, 64'(got), 64'(v.ack));
    chk({v.name, ".rdata"}, 64'(dat_of(inst)), 64'(v.rdat));
    chk({v.name, ".strb_outside_access"}, 64'(late_strb), 64'(0));
    @(negedge clk);
    chk({v.name, ".ack_single"}, 64'(ack_of(inst)), 64'(0));
  endtask

  initial begin
    int   got;
    logic any;
    vec_t v;

    spike = 256'd0;
    spike[100] = 1'b1;
    we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;

    //        name         we    adr            dat            sel   strb   wmask saddr   pnum   pword ack rdat
    vecs[0] = '{"syn_wr",  1'b1, 32'h3000_0124, 32'hDEADBEEF, 4'hF, 4'b1100, 4'hF, 11'h049, 5'h12, 2'd1, 2, 32'h0};
    vecs[1] = '{"syn_rd",  1'b0, 32'h3000_0124, 32'h0,        4'hF, 4'b1000, 4'hF, 11'h049, 5'h12, 2'd1, 3, 32'hDEADBEEF};
    vecs[2] = '{"par_wr",  1'b1, 32'h3000_2058, 32'h12345678, 4'hF, 4'b0010, 4'h0, 11'h016, 5'h05, 2'd2, 2, 32'h0};
    vecs[3] = '{"par_wrp", 1'b1, 32'h3000_2058, 32'h12345678, 4'h3, 4'b0000, 4'h0, 11'h016, 5'h05, 2'd2, 2, 32'h0};
    vecs[4] = '{"par_rd",  1'b0, 32'h3000_2058, 32'h0,        4'hF, 4'b0001, 4'h0, 11'h016, 5'h05, 2'd2, 2, 32'hA500_0016};
    vecs[5] = '{"spk_rd",  1'b0, 32'h3000_400C, 32'h0,        4'hF, 4'b0000, 4'h0, 11'h003, 5'h00, 2'd3, 2, 32'h0000_0010};
    vecs[6] = '{"spk_wr",  1'b1, 32'h3000_400C, 32'h55555555, 4'hF, 4'b0000, 4'h0, 11'h003, 5'h00, 2'd3, 2, 32'h0};
    vecs[7] = '{"spk_rd2", 1'b0, 32'h3000_400C, 32'h0,        4'hF, 4'b0000, 4'h0, 11'h003, 5'h00, 2'd3, 2, 32'h0000_0010};
    vecs[8] = '{"unm_rd",  1'b0, 32'h3000_6000, 32'h0,        4'hF, 4'b0000, 4'h0, 11'h000, 5'h00, 2'd0, 2, 32'h0};
    vecs[9] = '{"syn_rdp", 1'b0, 32'h3000_0124, 32'h0,        4'h3, 4'b1000, 4'h3, 11'h049, 5'h12, 2'd1, 3, 32'hDEADBEEF};

    // Reset state
    #12;
    chk("rst.ack", 64'(ack1), 64'(0));
    chk("rst.dat", 64'(dat1), 64'(0));
    chk("rst.strb", 64'({strb_of(1), wm1}), 64'(0));
    chk("rst.regs", {sa1, pn1, pw1, pwd1[15:0]}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(1, vecs[i]);

    // Write data reaches the parameter port and is held after the access.
    v = vecs[2];
    v.name = "par_wr2"; v.dat = 32'hCAFEF00D;
    run_vec(1, v);
    repeat (3) @(negedge clk);
    chk("par_wdata_hold", 64'(pwd1), 64'(32'hCAFEF00D));

    // Miss: no ack and no strobes for 10 cycles
    @(negedge clk);
    we = 1'b0; adr = 32'h3100_0000; sel = 4'hF;
    set_cyc(1, 1'b1);
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack1 || strb_of(1) != 4'h0) any = 1'b1;
    end
    set_cyc(1, 1'b0);
    chk("miss.no_ack", 64'(any), 64'(0));

    // Latency-3 synapse path
    v = vecs[0]; v.name = "l3_wr"; run_vec(3, v);
    v = vecs[1]; v.name = "l3_rd"; v.ack = 5; run_vec(3, v);

    // cyc drops during WAIT: silent abort, read data untouched
    @(negedge clk);
    we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
    set_cyc(3, 1'b1);
    repeat (2) @(negedge clk);   // cycle 2: WAIT
    set_cyc(3, 1'b0);
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack3) any = 1'b1;
    end
    chk("abort.no_ack", 64'(any), 64'(0));
    chk("abort.dat_hold", 64'(dat3), 64'(32'hDEADBEEF));
    v = vecs[8]; v.name = "abort.next"; run_vec(3, v);

    // Reset asserted during WAIT
    v = vecs[1]; v.name = "l3_rd2"; v.ack = 5; run_vec(3, v);
    @(negedge clk);
    we = 1'b0; adr = 32'h3000_0124; sel = 4'hF;
    set_cyc(3, 1'b1);
    repeat (3) @(negedge clk);   // cycle 3: WAIT
    #1 rst_n = 1'b0;
    #1;
    chk("wrst.ack", 64'(ack3), 64'(0));
    chk("wrst.dat", 64'(dat3), 64'(0));
    chk("wrst.strb", 64'({strb_of(3), wm3}), 64'(0));
    chk("wrst.regs", {sa3, pn3, pw3, 16'h0}, 64'(0));
    chk("wrst.wdata", {swd3, pwd3}, 64'(0));
    set_cyc(3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack3) any = 1'b1;
    end
    chk("wrst.no_ack", 64'(any), 64'(0));
    v = vecs[5]; v.name = "wrst.next"; run_vec(3, v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
